// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - shared opcodes, default sizes and the full-adder cell
// Reused by the ALU front-end; keep OP_* encodings stable.
package pipelined_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic cout;
    logic s;
  } fa_t;

  function automatic fa_t full_add(input logic a, input logic b, input logic cin);
    fa_t r;
    r.s    = a ^ b ^ cin;
    r.cout = (a & b) | (cin & (a ^ b));
    return r;
  endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// rtl/pipelined_adder_chunk.sv - combinational CHUNK-bit ripple adder built from full-adder cells
module adder_chunk
  import pipelined_adder_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  always_comb begin
    logic carry;
    fa_t  fa;
    carry = cin;
    fa    = '0;
    s     = '0;
    for (int i = 0; i < CHUNK; i++) begin
      fa    = full_add(a[i], b[i], carry);
      s[i]  = fa.s;
      carry = fa.cout;
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - pipelined adder/subtractor, one CHUNK-bit slice per stage
// Stage k owns slice k; operands skew forward and finished sum slices deskew alongside.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if ((WIDTH % CHUNK) != 0 || WIDTH < CHUNK) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a nonzero multiple of CHUNK");
  end

  logic             advance;
  logic             v_q   [STAGES];
  logic             sub_q [STAGES];
  logic             c_q   [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_nx  [STAGES];
  logic [CHUNK-1:0] sum_w [STAGES];
  logic             co_w  [STAGES];

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a   (a_q[k][k*CHUNK +: CHUNK]),
      .b   (b_q[k][k*CHUNK +: CHUNK]),
      .cin (c_q[k]),
      .s   (sum_w[k]),
      .cout(co_w[k])
    );
  end

  // Each stage drops its freshly computed slice into the travelling partial sum.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_nx[k] = s_q[k];
      s_nx[k][k*CHUNK +: CHUNK] = sum_w[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
      end
      out_valid <= 1'b0;
      S         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      v_q[0]   <= in_valid;
      sub_q[0] <= sub;
      c_q[0]   <= (sub == OP_SUB);
      a_q[0]   <= A;
      b_q[0]   <= (sub == OP_SUB) ? ~B : B;
      s_q[0]   <= '0;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k]   <= v_q[k-1];
        sub_q[k] <= sub_q[k-1];
        c_q[k]   <= co_w[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        s_q[k]   <= s_nx[k-1];
      end
      out_valid <= v_q[LAST];
      S         <= s_nx[LAST];
      cout      <= co_w[LAST];
      ovf       <= (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                   (s_nx[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder
module tb_pipelined_adder;

  localparam int W      = 16;
  localparam int STAGES = 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] A, B, S;
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  bit           rand_on = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           issue;
    bit           lat;
  } exp_t;

  exp_t sb[$];
  exp_t me;

  pipelined_adder #(.WIDTH(W), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Whole-word reference: {cout,S} = A + B' + cin at W+1 bits.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t         e;
    logic [W-1:0] bp;
    logic [W:0]   t;
    bp      = s ? ~b : b;
    t       = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, s};
    e.s     = t[W-1:0];
    e.c     = t[W];
    e.o     = (a[W-1] == bp[W-1]) && (t[W-1] != a[W-1]);
    e.issue = 0;
    e.lat   = 0;
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
    int n = 0;
    A = a; B = b; sub = s; in_valid = 1'b1;
    do begin
      @(posedge clk);
      n++;
    end while (!in_ready && n < 200);
    chk("send_accept", in_ready, 1);
    if (in_ready) begin
      e.issue = cyc;
      sb.push_back(e);
    end
    #1;
  endtask

  task automatic send_m(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit lat);
    exp_t e;
    e     = model(a, b, s);
    e.lat = lat;
    send(a, b, s, e);
  endtask

  task automatic send_d(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    e.s = es; e.c = ec; e.o = eo; e.issue = 0; e.lat = 1;
    send(a, b, s, e);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", out_valid, 0);
      end else begin
        me = sb.pop_front();
        chk("sum", S, me.s);
        chk("cout", cout, me.c);
        chk("ovf", ovf, me.o);
        if (me.lat) chk("latency", cyc - me.issue - 1, STAGES);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_on) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [W-1:0] ha, hb;
    logic         hs;
    rst = 1'b1; in_valid = 1'b1; A = 16'h1234; B = 16'h4321; sub = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_S", S, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);
    chk("valid_after_rst", out_valid, 0);

    send_d(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    send_d(16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
    send_d(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_d(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    drain();

    for (int i = 0; i < 8; i++) send_m(W'(i), W'(16'h1111 * i), i[0], 1'b1);
    drain();

    for (int i = 0; i < 5; i++) send_m(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    ha = W'($urandom); hb = W'($urandom); hs = 1'($urandom);
    out_ready = 1'b0; A = ha; B = hb; sub = hs; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_S", S, sb[0].s);
      chk("stall_cout", cout, sb[0].c);
      chk("stall_ovf", ovf, sb[0].o);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_m(ha, hb, hs, 1'b0);
    send_m(W'($urandom), W'($urandom), 1'b1, 1'b0);
    drain();

    for (int i = 0; i < 3; i++) send_m(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    A = W'($urandom); in_valid = 1'b1; rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("flushed_valid", out_valid, 0);
    end
    send_m(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    drain();

    rand_on = 1;
    for (int i = 0; i < 40; i++) begin
      send_m(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    rand_on = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    chk("final_queue_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor, the multi-bit successor to the team's 4-bit ripple full adder. Operands are split into CHUNK-bit slices that ripple one slice per clock, so carry-chain delay is bounded by one slice regardless of WIDTH. The block accepts one operation per cycle through a valid/ready handshake and returns sum, carry-out and signed-overflow in issue order. It sits between operand sources, such as switch registers or the ALU front-end, and result consumers, such as display drivers.

## Interface
- WIDTH, 16: operand and result width; must be a multiple of CHUNK and at least CHUNK.
- CHUNK, 4: bits added per pipeline stage; STAGES = WIDTH/CHUNK.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result this cycle.
- S  out  WIDTH  sum or difference (low WIDTH bits).
- cout  out  1  carry out of the MSB; for subtraction, 1 = no borrow (A ≥ B unsigned).
- ovf  out  1  signed overflow.

## Operation
- Beat accepted when in_valid && in_ready; result delivered when out_valid && out_ready.
- Subtraction: effective B' = ~B, carry-in = 1. Addition: B' = B, carry-in = 0.
- Stage k (0..STAGES−1) adds slice k of A and B' plus the carry registered by stage k−1 (stage 0 uses the carry-in).
- Skew registers delay the upper operand slices so each reaches its stage with the matching carry.
- Deskew registers delay the completed lower sum slices so all slices of S emerge aligned.
- Each stage carries a valid bit and the sub flag of its beat.
- Arithmetic rules: {cout, S} = A + B' + cin, computed at WIDTH+1 bits. ovf = (A[MSB] == B'[MSB]) && (S[MSB] != A[MSB]).
- Stall is global: advance = !out_valid || out_ready. When advance is 0, every pipeline register, including output S/cout/ovf, holds its value.
- in_ready = advance && !rst.
- No FSM beyond the per-stage valid shift register. The pipeline is either advancing or stalled.

## Timing
- Latency: a beat accepted at edge n presents out_valid at edge n+STAGES (4 cycles with defaults), provided no stall intervenes. Each stall cycle adds exactly one cycle.
- Throughput: one beat per cycle while out_ready stays high.
- Reset: during rst and on the cycle after, out_valid=0, S=0, cout=0, ovf=0, and in_ready=0 while rst is high. All stage valid bits and the carry registers clear.
- Reset mid-operation: all in-flight beats are discarded and never appear at the output. A beat presented on the rst cycle is not accepted.
- Simultaneous accept and deliver while full is legal: the pipeline shifts and both handshakes complete in the same cycle.
- out_valid high with out_ready low: S/cout/ovf stay stable until the beat is taken, and in_ready=0.
- Wrap-around: results are modulo 2^WIDTH. Overflow is flagged, never saturated.

## Structure
- Shared package/header holds OP_ADD=1'b0, OP_SUB=1'b1 and the default WIDTH/CHUNK constants, which are reused by the ALU.
- Sub-module adder_chunk: a combinational CHUNK-bit ripple adder (a, b, cin → s, cout) built from the existing full-adder cell.
  - STAGES instances are generated.
  - Sequential logic (skew, deskew, valid, carry registers, stall) lives only in pipelined_adder.
- Parameter check: elaboration fails if WIDTH % CHUNK != 0.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 → out_valid=0, S=0, cout=0, ovf=0, in_ready=0 throughout. in_ready=1 the cycle after rst drops.
- Add with overflow: A=0x8000, B=0xFFFF, sub=0 → after 4 cycles S=0x7FFF, cout=1, ovf=1. Chunk carry case: A=0x0FFF, B=0x0001 → S=0x1000, cout=0, ovf=0.
- Subtract: A=0x0005, B=0x0007, sub=1 → S=0xFFFE, cout=0, ovf=0. A=0x8000, B=0x0001, sub=1 → S=0x7FFF, cout=1, ovf=1.
- Streaming: 8 back-to-back beats (A=i, B=0x1111·i, alternating sub) with out_ready=1 → 8 consecutive out_valid cycles starting at cycle 4, in order, each matching the reference model.
- Backpressure: fill the pipeline, then drop out_ready for 3 cycles → S/cout/ovf held, in_ready=0, no beat lost or duplicated. Order is preserved after release.
- Mid-flight reset: 3 beats in flight, pulse rst for 1 cycle → no out_valid for those beats. The next accepted beat emerges 4 cycles after acceptance with the correct result.
